// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NAND = 4'd2,
    OP_NOR  = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NOT  = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8,
    OP_MUL  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int OP_LAST_LEGAL = 9;

endpackage

// File: rtl/seq_alu_mul.sv
// Unsigned shift-add multiplier, one partial-product step per cycle.
module seq_alu_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     sum;

  // low half holds the unconsumed multiplier bits
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
        + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  // prod is the value after the final step
  assign done = busy_q && (cnt_q == CW'(WIDTH-1));
  assign prod = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      acc_q   <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered N-bit ALU with valid/ready handshake and Z/N/C/V flags.
// Define ALU_MUL_EN to enable the multi-cycle unsigned multiply (op 9).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err_op
);

  alu_state_e state_q, state_d;

  logic             accept;
  logic             is_mul;
  logic             legal;
  logic [WIDTH-1:0] bb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_c;
  logic             c_c, v_c;

  logic [WIDTH-1:0] result_q;
  logic             z_q, n_q, c_q, v_q, err_q;

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   hi_q;

  assign is_mul = (op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hi_q <= '0;
    else if (accept && !is_mul) hi_q <= '0;
    else if (mul_done)         hi_q <= mul_prod[2*WIDTH-1:WIDTH];
  end

  assign res_hi = hi_q;
`else
  assign is_mul = 1'b0;
  assign res_hi = '0;
`endif

  // SUB reuses the adder as a + ~b + 1
  always_comb begin
    legal = (op <= 4'(OP_LAST_LEGAL));
`ifndef ALU_MUL_EN
    if (op == OP_MUL) legal = 1'b0;
`endif
    bb  = (op == OP_SUB) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb}
        + {{WIDTH{1'b0}}, (op == OP_SUB)};
    r_c = '0;
    c_c = 1'b0;
    v_c = 1'b0;
    case (op)
      OP_AND:  r_c = a & b;
      OP_OR:   r_c = a | b;
      OP_NAND: r_c = ~(a & b);
      OP_NOR:  r_c = ~(a | b);
      OP_XOR:  r_c = a ^ b;
      OP_XNOR: r_c = ~(a ^ b);
      OP_NOT:  r_c = ~a;
      OP_ADD, OP_SUB: begin
        r_c = sum[WIDTH-1:0];
        c_c = sum[WIDTH];
        v_c = (a[WIDTH-1] == bb[WIDTH-1])
           && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
    if (!legal) begin
      r_c = '0;
      c_c = 1'b0;
      v_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept)
          state_d = is_mul ? BUSY : DONE;
        else if (state_q == DONE && out_ready)
          state_d = IDLE;
      end
`ifdef ALU_MUL_EN
      BUSY:    state_d = mul_done ? DONE : BUSY;
`else
      BUSY:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE)
             || (state_q == DONE && out_ready);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q <= r_c;
      z_q      <= legal && (r_c == '0);
      n_q      <= r_c[WIDTH-1];
      c_q      <= c_c;
      v_q      <= v_c;
      err_q    <= !legal;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      result_q <= mul_prod[WIDTH-1:0];
      z_q      <= (mul_prod == '0);
      n_q      <= mul_prod[2*WIDTH-1];
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end
`endif
  end

  assign result = result_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign err_op = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized bench for seq_alu with an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic z, n, c, v, err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result, res_hi;
  logic         flag_z, flag_n, flag_c, flag_v, err_op;

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  exp_t eq[$];
  int   rq[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_hi(res_hi),
    .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v),
    .err_op(err_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic int sgn(input int u);
    return (u >= (1 << (W-1))) ? u - (1 << W) : u;
  endfunction

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    int ux, uy, r, full, s, lim;
    e = '0;
    ux = int'(x);
    uy = int'(y);
    lim = 1 << (W-1);
    r = 0;
    if (o > 4'd9 || (o == 4'd9 && !MUL_ON)) begin
      e.err = 1'b1;
      return e;
    end
    case (o)
      4'd0: r = ux & uy;
      4'd1: r = ux | uy;
      4'd2: r = ~(ux & uy);
      4'd3: r = ~(ux | uy);
      4'd4: r = ux ^ uy;
      4'd5: r = ~(ux ^ uy);
      4'd6: r = ~ux;
      4'd7: begin
        full = ux + uy;
        r = full;
        e.c = full >= (1 << W);
        s = sgn(ux) + sgn(uy);
        e.v = (s >= lim) || (s < -lim);
      end
      4'd8: begin
        r = ux - uy;
        e.c = ux >= uy;
        s = sgn(ux) - sgn(uy);
        e.v = (s >= lim) || (s < -lim);
      end
      default: begin
        full = ux * uy;
        e.res = W'(full);
        e.hi = W'(full >> W);
        e.z = (full == 0);
        e.n = 1'((full >> (2*W-1)) & 1);
        return e;
      end
    endcase
    r = r & ((1 << W) - 1);
    e.res = W'(r);
    e.z = (r == 0);
    e.n = 1'((r >> (W-1)) & 1);
    return e;
  endfunction

  always @(negedge clk) begin
    logic busy;
    logic [31:0] got;
    got = 32'({result, res_hi, flag_z, flag_n,
               flag_c, flag_v, err_op});
    if (!rst_n) begin
      eq.delete();
      rq.delete();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_outputs", got, 0);
    end else begin
      busy = 1'b0;
      if (eq.size() > 0) busy = (cyc < rq[0]);
      chk("in_ready", 32'(in_ready),
          32'(eq.size() == 0 || (!busy && out_ready)));
      chk("out_valid", 32'(out_valid),
          32'(eq.size() > 0 && !busy));
      if (out_valid && eq.size() > 0 && !busy) begin
        chk("outputs", got, 32'(eq[0]));
        if (out_ready) begin
          void'(eq.pop_front());
          void'(rq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        eq.push_back(model(op, a, b));
        rq.push_back(cyc +
          ((op == 4'd9 && MUL_ON) ? W + 1 : 1));
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o,
                      input logic [W-1:0] x,
                      input logic [W-1:0] y);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    if (!got) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    send(4'd7, 4'hF, 4'h1);
    @(negedge clk);
    chk("add_ovalid", 32'(out_valid), 1);
    chk("add_res", 32'(result), 0);
    chk("add_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b1010);
    step();

    send(4'd8, 4'h8, 4'h1);
    @(negedge clk);
    chk("sub_res", 32'(result), 7);
    chk("sub_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b0011);
    step();
    send(4'd5, 4'hA, 4'h6);
    @(negedge clk);
    chk("xnor_res", 32'(result), 3);
    chk("xnor_zc", 32'({flag_z, flag_c}), 0);
    step();

    send(4'd9, 4'hF, 4'hF);
    if (MUL_ON) begin
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        chk("mul_busy_ready", 32'(in_ready), 0);
      end
      @(negedge clk);
      chk("mul_ovalid", 32'(out_valid), 1);
      chk("mul_prod", 32'({res_hi, result}), 32'hE1);
      chk("mul_cv", 32'({flag_c, flag_v, err_op}), 0);
    end else begin
      @(negedge clk);
      chk("mul_off_err", 32'(err_op), 1);
      chk("mul_off_hi", 32'({res_hi, result}), 0);
    end
    step();

    out_ready = 1'b0;
    send(4'd1, 4'h3, 4'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_res", 32'(result), 7);
      chk("hold_ready", 32'(in_ready), 0);
    end
    step();
    out_ready = 1'b1;
    send(4'd0, 4'h5, 4'h3);
    @(negedge clk);
    chk("b2b_res", 32'(result), 1);
    chk("b2b_ovalid", 32'(out_valid), 1);
    step();

    send(4'hC, 4'h7, 4'h7);
    @(negedge clk);
    chk("illegal", 32'({result, res_hi, flag_z, flag_n,
        flag_c, flag_v, err_op}), 1);
    step();

    send(4'd7, 4'h1, 4'h1);
    send(4'd9, 4'h7, 4'h3);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_res", 32'(result), 0);
    chk("rst_mid_valid", 32'(out_valid), 0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(in_ready), 1);
    step();
    send(4'd7, 4'h2, 4'h3);
    @(negedge clk);
    chk("post_rst_add", 32'(result), 5);
    step();

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      op = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2*W + 4) step();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
